axi_rr_arbiter: RTL and testbench
=================================

# axi_rr_arbiter

Round-robin arbiter that shares one registered valid/ready output stage between NUM_REQ upstream requesters. Each requester sends packets, which are sequences of beats closed by `last`. Once a requester is granted, it owns the output until its last beat is accepted, so packets are never interleaved. The block sits in front of a single downstream processing stage and merges several producers onto it. It tags every output beat with the source index.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..8.
- `DWIDTH`, default 8: data width per beat.
- `IDW` (localparam) = `$clog2(NUM_REQ)`: width of the source index.

Ports:
- `aclk_i`  in  1  clock; all logic on the rising edge.
- `areset_i`  in  1  synchronous, active-low reset (0 = reset).
- `valid_i`  in  NUM_REQ  per-requester valid.
- `data_i`  in  NUM_REQ*DWIDTH  packed data; requester k occupies bits [k*DWIDTH +: DWIDTH].
- `last_i`  in  NUM_REQ  per-requester end-of-packet flag, qualified by the matching `valid_i`.
- `ready_o`  out  NUM_REQ  per-requester ready; at most one bit is high in any cycle.
- `valid_o`  out  1  downstream valid (registered).
- `data_o`  out  DWIDTH  downstream data (registered).
- `last_o`  out  1  downstream end-of-packet (registered).
- `id_o`  out  IDW  source index of the beat on `data_o` (registered).
- `ready_i`  in  1  downstream ready.
- `busy_o`  out  1  high while a grant is held (state BUSY).

## Operation
- The state machine has two states, IDLE and BUSY. Internal registers are `grant` (IDW bits) and `ptr` (IDW bits, the round-robin start index).
- **IDLE**
  - All `ready_o` bits are 0.
  - If any `valid_i` bit is set, select the first set index scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Register the selected index into `grant` and move to BUSY.
  - If no `valid_i` bit is set, stay in IDLE.
- **BUSY**
  - `ready_o[grant] = ~valid_o | ready_i`; all other `ready_o` bits are 0.
  - Input accept: `ready_o[grant] & valid_i[grant]`.
  - Output accept: `valid_o & ready_i`.
- **Output register** (same rule as a single-stage pipeline):
  - On input accept, load `data_o` from the granted data slice, `last_o` from `last_i[grant]` and `id_o` from `grant`, and set `valid_o` = 1.
  - Otherwise, on output accept, clear `valid_o` = 0. `data_o`, `last_o` and `id_o` hold their values.
  - Otherwise, all outputs hold.
- **Packet end**
  - An input accept with `last_i[grant]` = 1 moves BUSY to IDLE.
  - On that transition, `ptr` is set to (grant+1) mod NUM_REQ. Wrap is explicit, because NUM_REQ need not be a power of two.
- **Data stability**
  - Requesters must hold `valid_i` and `data_i` stable until accepted.
  - The arbiter never drops or duplicates a beat.
  - Dropping `valid_i[grant]` mid-packet stalls the arbiter in BUSY with no timeout.
- **Granted requester**
  - `valid_i` on non-granted requesters is ignored until the next IDLE cycle.
  - A single-beat packet (`last_i` = 1 on the first beat) is legal.
- **Reset** (`areset_i` = 0 at a clock edge), applied from any state including mid-packet:
  - `valid_o`=0, `data_o`=0, `last_o`=0, `id_o`=0, `busy_o`=0, `ready_o`=0.
  - State returns to IDLE; `grant`=0, `ptr`=0.
  - A beat held in the output register is discarded.

## Timing
- Arbitration latency:
  - Cycle n: in IDLE with `valid_i` seen.
  - Cycle n+1: BUSY, first beat can be accepted.
  - Cycle n+2: first beat appears on `valid_o`.
- Throughput within a packet is 1 beat/cycle while `ready_i`=1.
- Packet boundary:
  - Last beat accepted at cycle k; IDLE at k+1; the next packet's first beat is accepted at k+2 and appears on `valid_o` at k+3.
  - This gives exactly one output bubble between packets when `ready_i` is held at 1.
- Back-pressure:
  - With `valid_o`=1 and `ready_i`=0, `ready_o[grant]`=0 and the output holds.
  - `ready_i` rising lets an output accept and a new input accept happen in the same cycle with no bubble.
- `busy_o` goes high the cycle after IDLE arbitration and low the cycle after the last-beat input accept.
- Fairness: with all requesters continuously valid, grants cycle through 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 packets.

## Test plan
- **Reset:**
  - Stimulus: hold `areset_i`=0 for 3 cycles with `valid_i`=4'b1111.
  - Required response: all outputs are 0, `ready_o`=0, then the first grant after release is requester 0.
- **Single source:**
  - Stimulus: requester 2 sends a 3-beat packet 0x10, 0x11, 0x12 (last on 0x12) with `ready_i`=1.
  - Required response: `data_o` shows 0x10, 0x11, 0x12 with `id_o`=2 on consecutive cycles starting 2 cycles after `valid_i` rises; `last_o`=1 only on 0x12.
- **Round-robin:**
  - Stimulus: all 4 requesters continuously send 2-beat packets with data = 0xA0+k.
  - Required response: `id_o` sequence per packet is 0,1,2,3,0; exactly one bubble between packets.
- **Back-pressure:**
  - Stimulus: hold `ready_i`=0 for 5 cycles mid-packet.
  - Required response: `data_o` and `valid_o` are stable; `ready_o` is all 0; on release no beat is lost or duplicated (scoreboard compare).
- **No interleave:**
  - Stimulus: requester 1 holds a 4-beat packet while requester 0 asserts valid at beat 2.
  - Required response: all 4 beats carry `id_o`=1 before any beat with `id_o`=0; the next grant is 0 only after `ptr` wraps (2,3,0) among requesters that are valid.
- **Reset mid-packet:**
  - Stimulus: assert reset after beat 2 of a 4-beat packet from requester 3.
  - Required response: `valid_o`=0 on the next cycle, state IDLE, `ptr`=0; a fresh packet from requester 3 is then granted and delivered intact.

Source files
------------

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - round-robin packet arbiter feeding one registered valid/ready output stage
module axi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                      aclk_i,
    input  logic                      areset_i,
    input  logic [NUM_REQ-1:0]        valid_i,
    input  logic [NUM_REQ*DWIDTH-1:0] data_i,
    input  logic [NUM_REQ-1:0]        last_i,
    output logic [NUM_REQ-1:0]        ready_o,
    output logic                      valid_o,
    output logic [DWIDTH-1:0]         data_o,
    output logic                      last_o,
    output logic [IDW-1:0]            id_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] sel;
    logic           slot_rdy;
    logic           in_acc;
    logic           out_acc;

    // NUM_REQ need not be a power of two, so the wrap is done explicitly.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

    // Scan from the far end back towards ptr so the first valid index after ptr wins.
    always_comb begin
        sel = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_i[wrap_idx(ptr_q, i)]) begin
                sel = wrap_idx(ptr_q, i);
            end
        end
    end

    assign slot_rdy = ~valid_o | ready_i;
    assign in_acc   = (state_q == BUSY) & slot_rdy & valid_i[grant_q];
    assign out_acc  = valid_o & ready_i;
    assign busy_o   = (state_q == BUSY);

    always_comb begin
        ready_o = '0;
        if (areset_i && (state_q == BUSY) && slot_rdy) begin
            ready_o[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|valid_i) begin
                    grant_d = sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_acc && last_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (!areset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            id_o    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            if (in_acc) begin
                valid_o <= 1'b1;
                data_o  <= data_i[grant_q*DWIDTH +: DWIDTH];
                last_o  <= last_i[grant_q];
                id_o    <= grant_q;
            end else if (out_acc) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb/tb_axi_rr_arbiter.sv - directed self-checking bench for axi_rr_arbiter
module tb_axi_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic          aclk_i = 1'b0;
    logic          areset_i;
    logic [NR-1:0] valid_i;
    logic [NR*DW-1:0] data_i;
    logic [NR-1:0] last_i;
    logic [NR-1:0] ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic [1:0]    id_o;
    logic          ready_i;
    logic          busy_o;

    axi_rr_arbiter #(.NUM_REQ(NR), .DWIDTH(DW)) dut (
        .aclk_i   (aclk_i),
        .areset_i (areset_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .last_i   (last_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .id_o     (id_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o)
    );

    always #5 aclk_i = ~aclk_i;

    logic [8:0]  src_q [NR][$];
    logic [10:0] log_q[$];
    int          log_cyc[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        rdy = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive from source queues, log output accepts, pop accepted beats.
    task automatic step();
        logic [NR-1:0] acc;
        for (int k = 0; k < NR; k++) begin
            if (src_q[k].size() > 0) begin
                valid_i[k]        = 1'b1;
                data_i[k*DW +: DW] = src_q[k][0][7:0];
                last_i[k]         = src_q[k][0][8];
            end else begin
                valid_i[k]        = 1'b0;
                data_i[k*DW +: DW] = '0;
                last_i[k]         = 1'b0;
            end
        end
        ready_i = rdy;
        #1;
        if (areset_i && valid_o && ready_i) begin
            log_q.push_back({id_o, last_o, data_o});
            log_cyc.push_back(cyc);
        end
        acc = ready_o & valid_i;
        @(posedge aclk_i);
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) void'(src_q[k].pop_front());
        end
        cyc++;
        @(negedge aclk_i);
    endtask

    task automatic drain();
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0
                || busy_o || valid_o) && n < 300) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n < 300), 32'd1);
        step();
    endtask

    task automatic check_beat(input string tag, input int idx, input int id, input int data, input int last);
        logic [10:0] got;
        got = (idx < log_q.size()) ? log_q[idx] : 11'h7ff;
        check(tag, 32'(got), 32'((id << 9) | (last << 8) | data));
    endtask

    task automatic push_pkt(input int k, input int base, input int nbeats, input logic same);
        for (int b = 0; b < nbeats; b++) begin
            src_q[k].push_back({(b == nbeats - 1), 8'(same ? base : base + b)});
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        areset_i = 1'b0;
        valid_i  = '0;
        data_i   = '0;
        last_i   = '0;
        ready_i  = 1'b1;
        @(negedge aclk_i);

        // Reset with every requester valid
        for (int k = 0; k < NR; k++) push_pkt(k, 8'h50 + k, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outputs", {valid_o, data_o, last_o, id_o, busy_o, ready_o}, '0);
        end
        areset_i = 1'b1;
        clear_log();
        drain();
        check("rst_count", log_q.size(), 4);
        for (int k = 0; k < NR; k++) check_beat("rst_order", k, k, 8'h50 + k, 1);

        // Single source: requester 2, ptr is 0
        clear_log();
        push_pkt(2, 8'h10, 3, 1'b0);
        n = cyc;
        step();
        check("single_busy_hi", busy_o, 1);
        step(); step(); step();
        check("single_busy_lo", busy_o, 0);
        drain();
        check("single_count", log_q.size(), 3);
        for (int b = 0; b < 3; b++) begin
            check_beat("single_beat", b, 2, 8'h10 + b, (b == 2));
            check("single_cycle", (b < log_cyc.size()) ? log_cyc[b] : -1, n + 2 + b);
        end

        // Round robin from ptr 0 (reset clears ptr)
        areset_i = 1'b0;
        step();
        areset_i = 1'b1;
        clear_log();
        push_pkt(0, 8'hA0, 2, 1'b1);
        push_pkt(1, 8'hA1, 2, 1'b1);
        push_pkt(2, 8'hA2, 2, 1'b1);
        push_pkt(3, 8'hA3, 2, 1'b1);
        push_pkt(0, 8'hA0, 2, 1'b1);
        drain();
        check("rr_count", log_q.size(), 10);
        for (int p = 0; p < 5; p++) begin
            check_beat("rr_first", 2 * p, p % 4, 8'hA0 + (p % 4), 0);
            check_beat("rr_last", 2 * p + 1, p % 4, 8'hA0 + (p % 4), 1);
        end
        if (log_cyc.size() >= 10) begin
            for (int p = 0; p < 5; p++) check("rr_inpkt_gap", log_cyc[2*p+1] - log_cyc[2*p], 1);
            for (int p = 0; p < 4; p++) check("rr_bubble", log_cyc[2*p+2] - log_cyc[2*p+1], 2);
        end

        // Back-pressure: ptr is 1, requester 1 sends 4 beats
        clear_log();
        push_pkt(1, 8'h30, 4, 1'b0);
        step(); step(); step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", valid_o, 1);
            check("bp_data", data_o, 8'h31);
            check("bp_ready", ready_o, 0);
        end
        rdy = 1'b1;
        drain();
        check("bp_count", log_q.size(), 4);
        for (int b = 0; b < 4; b++) check_beat("bp_beat", b, 1, 8'h30 + b, (b == 3));

        // No interleave: ptr is 2, requester 0 joins during requester 1's packet
        clear_log();
        push_pkt(1, 8'h40, 4, 1'b0);
        step(); step(); step();
        push_pkt(0, 8'h60, 1, 1'b0);
        drain();
        check("ni_count", log_q.size(), 5);
        for (int b = 0; b < 4; b++) check_beat("ni_beat", b, 1, 8'h40 + b, (b == 3));
        check_beat("ni_next", 4, 0, 8'h60, 1);

        // Reset mid-packet: ptr is 1, requester 3 granted
        clear_log();
        push_pkt(3, 8'h70, 4, 1'b0);
        step(); step(); step(); step();
        areset_i = 1'b0;
        step();
        areset_i = 1'b1;
        check("mr_valid", valid_o, 0);
        check("mr_busy", busy_o, 0);
        check("mr_ready", ready_o, 0);
        check("mr_pre_count", log_q.size(), 2);
        check_beat("mr_pre0", 0, 3, 8'h70, 0);
        check_beat("mr_pre1", 1, 3, 8'h71, 0);
        src_q[3].delete();
        clear_log();
        push_pkt(3, 8'h80, 4, 1'b0);
        push_pkt(0, 8'h90, 1, 1'b0);
        drain();
        check("mr_count", log_q.size(), 5);
        check_beat("mr_ptr0", 0, 0, 8'h90, 1);
        for (int b = 0; b < 4; b++) check_beat("mr_fresh", b + 1, 3, 8'h80 + b, (b == 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
